// File: rtl/vga_pkg.sv
// Shared display geometry, pixel format and arbiter state encoding for the
// framebuffer scan-out path.
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int FB_WORDS     = DEF_H_ACTIVE * DEF_V_ACTIVE;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] a;
  } rgb_t;

  typedef enum logic [1:0] {S_WAIT, S_RUN, S_DONE} arb_state_t;
endpackage

// File: rtl/vga_pix_fifo.sv
// Small synchronous pixel FIFO with flush; a pop on empty and a push on full
// without a pop are ignored. DEPTH must be a power of 2, at least 2.
module vga_pix_fifo import vga_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [23:0]            din,
  input  logic                   pop,
  output logic [23:0]            dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  rgb_t [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a full FIFO still accepts a push in the same cycle as a pop
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_in)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out prefetch into a pixel FIFO, writer
// in spare slots with a starvation guard. VGA_FB_STATS_EN adds underflow_cnt.
module vga_fb_arbiter import vga_pkg::*; #(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              clock_div,
  input  logic              disp_active,
  input  logic              frame_start,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [23:0]       mem_wdata,
  input  logic [23:0]       mem_rdata,
  output logic [7:0]        R_out,
  output logic [7:0]        G_out,
  output logic [7:0]        A_out,
  output logic              underflow
`ifdef VGA_FB_STATS_EN
  ,
  output logic [15:0]       underflow_cnt
`endif
);
  localparam int FB_LIMIT = H_ACTIVE * V_ACTIVE;
  localparam int CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int WW       = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W:0] FB_END = (ADDR_W+1)'(FB_LIMIT);

  arb_state_t        state, state_nxt;
  logic [ADDR_W-1:0] fetch_addr;
  logic [WW-1:0]     wait_cnt;
  logic              rd_inflight;
  logic              fetch_need, force_wr, rd_grant, wr_grant, pop_req;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  rgb_t              fifo_dout, pix;

  assign pop_req = clock_div && disp_active;

  // frame_start blocks the fetch so the first read after a flush is address 0
  assign fetch_need = rst && !frame_start && (state == S_RUN) && !fifo_full &&
                      ({1'b0, fetch_addr} < FB_END) &&
                      ((CW+1)'(fifo_count) + (CW+1)'(rd_inflight) < (CW+1)'(FIFO_DEPTH));
  assign force_wr   = wr_valid && (wait_cnt == WW'(MAX_WAIT));

  always_ff @(posedge clk_in)
    if (!rst) state <= S_WAIT;
    else      state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (frame_start)
      state_nxt = S_RUN;
    else if (state == S_RUN && rd_grant && fetch_addr == ADDR_W'(FB_LIMIT - 1))
      state_nxt = S_DONE;
  end

  always_comb begin
    rd_grant  = fetch_need && !force_wr;
    wr_grant  = rst && wr_valid && !rd_grant;
    wr_ready  = wr_grant;
    mem_re    = rd_grant;
    mem_we    = wr_grant && ({1'b0, wr_addr} < FB_END);
    mem_addr  = rd_grant ? fetch_addr : wr_addr;
    mem_wdata = wr_data;
  end

  vga_pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in (clk_in),
    .rst    (rst),
    .flush  (frame_start),
    .push   (rd_inflight && !frame_start),
    .din    (mem_rdata),
    .pop    (pop_req),
    .dout   (fifo_dout),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      fetch_addr  <= '0;
      wait_cnt    <= '0;
      rd_inflight <= 1'b0;
      pix         <= '0;
      underflow   <= 1'b0;
    end else begin
      if (frame_start)   fetch_addr <= '0;
      else if (rd_grant) fetch_addr <= fetch_addr + ADDR_W'(1);
      rd_inflight <= rd_grant;
      if (!wr_valid || wr_grant)          wait_cnt <= '0;
      else if (wait_cnt != WW'(MAX_WAIT)) wait_cnt <= wait_cnt + WW'(1);
      if (clock_div) pix <= (disp_active && !fifo_empty) ? fifo_dout : '0;
      if (pop_req && fifo_empty) underflow <= 1'b1;
    end
  end

  assign R_out = pix.r;
  assign G_out = pix.g;
  assign A_out = pix.a;

`ifdef VGA_FB_STATS_EN
  always_ff @(posedge clk_in)
    if (!rst || frame_start)
      underflow_cnt <= '0;
    else if (pop_req && fifo_empty && underflow_cnt != 16'hFFFF)
      underflow_cnt <= underflow_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: behavioural RAM plus expected-contents array,
// pixel stream scoreboard and writer stall bookkeeping.
module tb_vga_fb_arbiter;
  import vga_pkg::*;
  localparam int ADDR_W = 19;
  localparam int RAMW   = 2048;
  localparam int FBW    = 640 * 480;

  logic              clk_in = 1'b0;
  logic              rst = 1'b0;
  logic              clock_div = 1'b0, disp_active = 1'b0, frame_start = 1'b0;
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [23:0]       wr_data = '0;
  logic              wr_ready, mem_re, mem_we, underflow;
  logic [ADDR_W-1:0] mem_addr;
  logic [23:0]       mem_wdata;
  logic [23:0]       mem_rdata = '0;
  logic [7:0]        R_out, G_out, A_out;
`ifdef VGA_FB_STATS_EN
  logic [15:0]       underflow_cnt;
`endif

  int checks = 0, errors = 0;
  int excl_viol = 0, oob_wr = 0;
  logic [23:0] ram [RAMW];
  bit          ram_ready = 1'b0;
  logic [23:0] exp_mem [RAMW];
  logic        s_re, s_we, s_rdy;
  logic [ADDR_W-1:0] s_addr;
  logic [23:0] pix_w;

  assign pix_w = {R_out, G_out, A_out};

  vga_fb_arbiter dut (
    .clk_in(clk_in), .rst(rst), .clock_div(clock_div), .disp_active(disp_active),
    .frame_start(frame_start), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .R_out(R_out), .G_out(G_out), .A_out(A_out), .underflow(underflow)
`ifdef VGA_FB_STATS_EN
    , .underflow_cnt(underflow_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Behavioural RAM: contents start as addr=data; reads return 1 cycle later.
  always @(posedge clk_in) begin
    if (!ram_ready) begin
      for (int i = 0; i < RAMW; i++) ram[i] <= 24'(i);
      ram_ready <= 1'b1;
    end else if (mem_we) begin
      if (mem_addr >= ADDR_W'(FBW)) oob_wr <= oob_wr + 1;
      else if (mem_addr < ADDR_W'(RAMW)) ram[mem_addr[10:0]] <= mem_wdata;
    end
    if (mem_re) mem_rdata <= (mem_addr < ADDR_W'(RAMW)) ? ram[mem_addr[10:0]] : 24'(mem_addr);
  end

  always @(negedge clk_in)
    if (mem_re && mem_we) excl_viol <= excl_viol + 1;

  task automatic cyc();
    @(negedge clk_in);
    s_re = mem_re; s_we = mem_we; s_rdy = wr_ready; s_addr = mem_addr;
    @(posedge clk_in); #1;
  endtask

  task automatic do_reset();
    rst = 0; clock_div = 0; disp_active = 0; frame_start = 0; wr_valid = 0;
    repeat (3) cyc();
    rst = 1;
  endtask

  task automatic new_write();
    wr_addr = ADDR_W'($urandom_range(2047, 1024));
    wr_data = 24'($urandom);
  endtask

  task automatic test_reset();
    rst = 0; wr_valid = 1; wr_addr = ADDR_W'(5); wr_data = 24'hABCDEF;
    clock_div = 1; disp_active = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (s_re !== 1'b0 || s_we !== 1'b0 || s_rdy !== 1'b0) begin
        errors++;
        $display("FAIL reset_strobes cyc %0d: re=%b we=%b rdy=%b, required 0 0 0", i, s_re, s_we, s_rdy);
      end
      checks++;
      if (pix_w !== 24'h0 || underflow !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d: pix=%h uf=%b, required 000000 0", i, pix_w, underflow);
      end
    end
`ifdef VGA_FB_STATS_EN
    checks++;
    if (underflow_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_ucnt: got %0d, required 0", underflow_cnt);
    end
`endif
    wr_valid = 0; clock_div = 0; disp_active = 0; rst = 1;
  endtask

  task automatic test_prefetch();
    int k;
    logic [23:0] last;
    do_reset();
    frame_start = 1; cyc(); frame_start = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (s_re !== 1'b1 || s_addr !== ADDR_W'(i)) begin
        errors++; $display("FAIL prefetch_addr %0d: re=%b addr=%0d, required re=1 addr=%0d", i, s_re, s_addr, i);
      end
    end
    k = 0; last = pix_w;
    for (int j = 0; j < 48; j++) begin
      clock_div = (j % 4 == 0); disp_active = (j != 20);
      cyc();
      checks++;
      if (clock_div && disp_active) begin
        if (pix_w !== exp_mem[k]) begin
          errors++; $display("FAIL prefetch_pix %0d: got %h, required %h", k, pix_w, exp_mem[k]);
        end
        k++;
      end else if (clock_div) begin
        if (pix_w !== 24'h0) begin
          errors++; $display("FAIL blank_pix: got %h, required 000000", pix_w);
        end
      end else if (pix_w !== last) begin
        errors++; $display("FAIL pix_hold cyc %0d: got %h, required %h", j, pix_w, last);
      end
      last = pix_w;
    end
    clock_div = 0; disp_active = 0;
    checks++;
    if (underflow !== 1'b0) begin
      errors++; $display("FAIL prefetch_underflow: got %b, required 0", underflow);
    end
  endtask

  task automatic test_contention();
    int k, stall, max_stall, nwr, bad;
    do_reset();
    frame_start = 1; cyc(); frame_start = 0;
    new_write(); wr_valid = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (s_re !== 1'b1 || s_addr !== ADDR_W'(i) || s_rdy !== 1'b0) begin
        errors++; $display("FAIL read_priority %0d: re=%b addr=%0d rdy=%b, required 1 %0d 0", i, s_re, s_addr, s_rdy, i);
      end
    end
    cyc();
    checks++;
    if (s_rdy !== 1'b1 || s_re !== 1'b0) begin
      errors++; $display("FAIL free_slot_write: rdy=%b re=%b, required 1 0", s_rdy, s_re);
    end
    nwr = 0; stall = 0; max_stall = 0; k = 0;
    if (s_rdy) begin exp_mem[wr_addr[10:0]] = wr_data; nwr++; new_write(); end
    for (int j = 0; j < 80; j++) begin
      clock_div = (j % 4 == 0); disp_active = 1;
      cyc();
      if (s_rdy) begin
        exp_mem[wr_addr[10:0]] = wr_data; nwr++; stall = 0; new_write();
      end else begin
        stall++; if (stall > max_stall) max_stall = stall;
      end
      if (clock_div) begin
        checks++;
        if (pix_w !== exp_mem[k]) begin
          errors++; $display("FAIL contention_pix %0d: got %h, required %h", k, pix_w, exp_mem[k]);
        end
        k++;
      end
    end
    wr_valid = 0; clock_div = 0; disp_active = 0;
    cyc();
    checks++;
    if (nwr < 10 || max_stall > 8) begin
      errors++; $display("FAIL contention_grants: writes=%0d max_stall=%0d, required >=10 and <=8", nwr, max_stall);
    end
    bad = 0;
    for (int i = 0; i < RAMW; i++) if (ram[i] !== exp_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL contention_ram: %0d words differ, required 0", bad);
    end
    checks++;
    if (excl_viol != 0 || underflow !== 1'b0) begin
      errors++; $display("FAIL contention_excl: re&we cycles=%0d uf=%b, required 0 0", excl_viol, underflow);
    end
  endtask

  task automatic test_forced();
    int k, stall, max_stall, nwr;
    bit saw8;
    do_reset();
    frame_start = 1; cyc(); frame_start = 0;
    repeat (6) cyc();
    new_write(); wr_valid = 1; clock_div = 1; disp_active = 1;
    k = 0; stall = 0; max_stall = 0; nwr = 0; saw8 = 0;
    for (int j = 0; j < 60; j++) begin
      cyc();
      if (s_rdy) begin
        if (stall == 8) saw8 = 1;
        exp_mem[wr_addr[10:0]] = wr_data; nwr++; stall = 0; new_write();
      end else begin
        stall++; if (stall > max_stall) max_stall = stall;
      end
      checks++;
      if (pix_w === exp_mem[k]) k++;
      else if (pix_w !== 24'h0) begin
        errors++; $display("FAIL forced_pix: got %h, required %h or 000000", pix_w, exp_mem[k]);
      end
    end
    wr_valid = 0; clock_div = 0; disp_active = 0;
    cyc();
    checks++;
    if (max_stall > 8 || !saw8 || nwr < 3) begin
      errors++; $display("FAIL forced_write: max_stall=%0d saw8=%b writes=%0d, required <=8 1 >=3", max_stall, saw8, nwr);
    end
    checks++;
    if (excl_viol != 0 || k < 8) begin
      errors++; $display("FAIL forced_excl: re&we cycles=%0d pixels=%0d, required 0 and >=8", excl_viol, k);
    end
  endtask

  task automatic test_oob_write();
    int bad;
    do_reset();
    wr_valid = 1; wr_addr = ADDR_W'(FBW); wr_data = 24'h123456;
    cyc();
    checks++;
    if (s_rdy !== 1'b1 || s_we !== 1'b0) begin
      errors++; $display("FAIL oob_write: rdy=%b we=%b, required 1 0", s_rdy, s_we);
    end
    wr_addr = ADDR_W'(FBW - 1);
    cyc();
    checks++;
    if (s_rdy !== 1'b1 || s_we !== 1'b1) begin
      errors++; $display("FAIL last_word_write: rdy=%b we=%b, required 1 1", s_rdy, s_we);
    end
    wr_addr = ADDR_W'(7); wr_data = 24'($urandom);
    cyc();
    checks++;
    if (s_rdy !== 1'b1 || s_we !== 1'b1 || s_addr !== ADDR_W'(7)) begin
      errors++; $display("FAIL inrange_write: rdy=%b we=%b addr=%0d, required 1 1 7", s_rdy, s_we, s_addr);
    end
    exp_mem[7] = wr_data;
    wr_valid = 0;
    cyc();
    checks++;
    if (oob_wr != 0) begin
      errors++; $display("FAIL oob_ram: %0d writes at >=%0d, required 0", oob_wr, FBW);
    end
    bad = 0;
    for (int i = 0; i < RAMW; i++) if (ram[i] !== exp_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL oob_ram_contents: %0d words differ, required 0", bad);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    clock_div = 1; disp_active = 1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if (pix_w !== 24'h0 || underflow !== 1'b1) begin
        errors++; $display("FAIL underflow_pop %0d: pix=%h uf=%b, required 000000 1", i, pix_w, underflow);
      end
`ifdef VGA_FB_STATS_EN
      checks++;
      if (underflow_cnt !== 16'(i + 1)) begin
        errors++; $display("FAIL underflow_cnt %0d: got %0d, required %0d", i, underflow_cnt, i + 1);
      end
`endif
    end
    clock_div = 0; disp_active = 0;
    repeat (3) cyc();
    checks++;
    if (underflow !== 1'b1) begin
      errors++; $display("FAIL underflow_sticky: got %b, required 1", underflow);
    end
  endtask

  task automatic test_midframe();
    int nre, k;
    do_reset();
    frame_start = 1; cyc(); frame_start = 0;
    cyc(); cyc();
    frame_start = 1; cyc(); frame_start = 0;
    nre = 0;
    for (int j = 0; j < 8; j++) begin
      cyc();
      if (s_re) begin
        checks++;
        if (s_addr !== ADDR_W'(nre)) begin
          errors++; $display("FAIL midframe_addr %0d: got %0d, required %0d", nre, s_addr, nre);
        end
        nre++;
      end
    end
    checks++;
    if (nre != 4) begin
      errors++; $display("FAIL midframe_reads: got %0d, required 4", nre);
    end
    k = 0;
    for (int j = 0; j < 8; j++) begin
      clock_div = (j % 2 == 0); disp_active = 1;
      cyc();
      if (clock_div) begin
        checks++;
        if (pix_w !== exp_mem[k]) begin
          errors++; $display("FAIL midframe_pix %0d: got %h, required %h", k, pix_w, exp_mem[k]);
        end
        k++;
      end
    end
    clock_div = 0; disp_active = 0;
    checks++;
    if (underflow !== 1'b0) begin
      errors++; $display("FAIL midframe_underflow: got %b, required 0", underflow);
    end
  endtask

  initial begin
    for (int i = 0; i < RAMW; i++) exp_mem[i] = 24'(i);
    test_reset();
    test_prefetch();
    test_contention();
    test_forced();
    test_oob_write();
    test_underflow();
    test_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
